// File: rtl/pll_rst_seq_pkg.sv
// Shared types, default parameters and helpers for the PLL reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    REL_CORE,
    RUN,
    FAULT
  } seq_state_t;

  typedef struct packed {
    logic pll_reset;
    logic core_rst_n;
    logic periph_rst_n;
    logic pll_ready;
    logic fault;
  } seq_out_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 50000;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_STAGE_GAP      = 16;
  localparam int DEF_MAX_RETRY      = 7;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  // Output pattern owned by each state; registered on entry to that state.
  function automatic seq_out_t state_outputs(input seq_state_t s);
    seq_out_t o;
    o = '{pll_reset: 1'b0, core_rst_n: 1'b0, periph_rst_n: 1'b0,
          pll_ready: 1'b0, fault: 1'b0};
    case (s)
      PLL_RST:  o.pll_reset = 1'b1;
      REL_CORE: o.core_rst_n = 1'b1;
      RUN: begin
        o.core_rst_n   = 1'b1;
        o.periph_rst_n = 1'b1;
        o.pll_ready    = 1'b1;
      end
      FAULT: begin
        o.pll_reset = 1'b1;
        o.fault     = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_rst_seq_bit_sync.sv
// N-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module bit_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[N-2:0], d};
  end

  assign q = r_sync[N-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer and lock monitor: drives the PLL reset, qualifies lock,
// and releases core then peripheral resets; retries the PLL on lock timeout.
//
// state     | meaning
// PLL_RST   | PLL reset held, counting PLL_RST_CYCLES
// WAIT_LOCK | PLL released, waiting for lock or timeout
// STABLE    | lock seen, counting consecutive locked cycles
// REL_CORE  | core released, waiting STAGE_GAP before peripherals
// RUN       | all domains released, monitoring lock
// FAULT     | retries exhausted, terminal until rst_n
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  parameter int CNT_W          = cnt_width(DEF_LOCK_TIMEOUT, DEF_STABLE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       extlock,
  input  logic       soft_rst_req,
  output logic       pll_reset,
  output logic       core_rst_n,
  output logic       periph_rst_n,
  output logic       pll_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  logic             w_lock_s;
  seq_state_t       r_state;
  seq_out_t         r_out;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;
  logic [7:0]       r_lol;

  bit_sync #(.N(SYNC_STAGES)) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (extlock),
    .q    (w_lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PLL_RST;
      r_out   <= state_outputs(PLL_RST);
      r_cnt   <= '0;
      r_retry <= '0;
      r_lol   <= '0;
    end else begin
      case (r_state)
        PLL_RST: begin
          if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
            r_state <= WAIT_LOCK;
            r_out   <= state_outputs(WAIT_LOCK);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= STABLE;
            r_out   <= state_outputs(STABLE);
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            r_retry <= r_retry + 4'd1;
            r_cnt   <= '0;
            if (r_retry + 4'd1 == 4'(MAX_RETRY)) begin
              r_state <= FAULT;
              r_out   <= state_outputs(FAULT);
            end else begin
              r_state <= PLL_RST;
              r_out   <= state_outputs(PLL_RST);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          // Any unlocked cycle restarts qualification but is not a retry.
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_out   <= state_outputs(WAIT_LOCK);
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            r_state <= REL_CORE;
            r_out   <= state_outputs(REL_CORE);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        REL_CORE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_out   <= state_outputs(WAIT_LOCK);
            r_cnt   <= '0;
          end else if (soft_rst_req) begin
            r_state <= STABLE;
            r_out   <= state_outputs(STABLE);
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
            r_state <= RUN;
            r_out   <= state_outputs(RUN);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          // Lock loss takes priority over a coincident soft reset request.
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_out   <= state_outputs(WAIT_LOCK);
            r_cnt   <= '0;
            if (r_lol != 8'hFF) r_lol <= r_lol + 8'd1;
          end else if (soft_rst_req) begin
            r_state <= STABLE;
            r_out   <= state_outputs(STABLE);
            r_cnt   <= '0;
          end
        end
        FAULT: begin
          r_out <= state_outputs(FAULT);
        end
        default: begin
          r_state <= FAULT;
          r_out   <= state_outputs(FAULT);
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign pll_reset     = r_out.pll_reset;
  assign core_rst_n    = r_out.core_rst_n;
  assign periph_rst_n  = r_out.periph_rst_n;
  assign pll_ready     = r_out.pll_ready;
  assign fault         = r_out.fault;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_lol;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed scoreboard bench for pll_rst_seq with small timing parameters.
module tb_pll_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       extlock = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       pll_reset, core_rst_n, periph_rst_n, pll_ready, fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pll_rst_seq #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (8),
    .STAGE_GAP     (3),
    .MAX_RETRY     (2),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .extlock      (extlock),
    .soft_rst_req (soft_rst_req),
    .pll_reset    (pll_reset),
    .core_rst_n   (core_rst_n),
    .periph_rst_n (periph_rst_n),
    .pll_ready    (pll_ready),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  function automatic int st(input bit pr, input bit cr, input bit pe, input bit rd,
                            input bit ft, input int rc, input int ll);
    logic [16:0] v;
    v = {pr, cr, pe, rd, ft, rc[3:0], ll[7:0]};
    return int'(v);
  endfunction

  function automatic int status();
    logic [16:0] v;
    v = {pll_reset, core_rst_n, periph_rst_n, pll_ready, fault, retry_cnt, lock_loss_cnt};
    return int'(v);
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_reset;
      1:       return core_rst_n;
      2:       return periph_rst_n;
      default: return fault;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int obs);
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    assert (obs === e.val)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
    end
  endtask

  // Edges until sig(sel)==val; -1 if the budget expires. saw_pr flags any pll_reset=1 seen.
  task automatic wait_sig(input int sel, input logic val, input int budget,
                          output int n, output bit saw_pr);
    n = -1;
    saw_pr = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      saw_pr = saw_pr | pll_reset;
      if (sig(sel) === val) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;

    tick(3);
    push("reset_state", st(1, 0, 0, 0, 0, 0, 0));
    pop_check(status());

    // Normal bring-up
    rst_n = 1'b1;
    push("t1_pll_reset_len", 4);
    wait_sig(0, 1'b0, 50, n, saw);
    pop_check(n);
    tick(6);
    extlock = 1'b1;
    push("t1_core_latency", 11);
    wait_sig(1, 1'b1, 50, n, saw);
    pop_check(n);
    push("t1_periph_gap", 3);
    wait_sig(2, 1'b1, 20, n, saw);
    pop_check(n);
    push("t1_run_state", st(0, 1, 1, 1, 0, 0, 0));
    pop_check(status());

    // Lock glitch during STABLE
    rst_n = 1'b0;
    tick(2);
    push("t2_reset_state", st(1, 0, 0, 0, 0, 0, 0));
    pop_check(status());
    rst_n = 1'b1;
    tick(8);
    extlock = 1'b0;
    tick(1);
    extlock = 1'b1;
    tick(4);
    push("t2_no_early_release", 0);
    pop_check(int'(core_rst_n));
    push("t2_core_latency", 7);
    wait_sig(1, 1'b1, 50, n, saw);
    pop_check(n);
    push("t2_periph_gap", 3);
    wait_sig(2, 1'b1, 20, n, saw);
    pop_check(n);
    push("t2_run_state", st(0, 1, 1, 1, 0, 0, 0));
    pop_check(status());

    // Lock loss in RUN
    extlock = 1'b0;
    tick(2);
    push("t4_still_released", 1);
    pop_check(int'(core_rst_n));
    tick(1);
    push("t4_dropped", st(0, 0, 0, 0, 0, 0, 1));
    pop_check(status());
    tick(17);
    extlock = 1'b1;
    push("t4_core_latency", 11);
    wait_sig(1, 1'b1, 50, n, saw);
    pop_check(n);
    push("t4_no_pll_pulse", 0);
    pop_check(int'(saw));
    push("t4_periph_gap", 3);
    wait_sig(2, 1'b1, 20, n, saw);
    pop_check(n);
    push("t4_run_state", st(0, 1, 1, 1, 0, 0, 1));
    pop_check(status());

    // Soft reset in RUN
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    push("t5_resets_asserted", st(0, 0, 0, 0, 0, 0, 1));
    pop_check(status());
    push("t5_core_latency", 8);
    wait_sig(1, 1'b1, 50, n, saw);
    pop_check(n);
    push("t5_no_pll_pulse", 0);
    pop_check(int'(saw));
    push("t5_periph_gap", 3);
    wait_sig(2, 1'b1, 20, n, saw);
    pop_check(n);
    push("t5_run_state", st(0, 1, 1, 1, 0, 0, 1));
    pop_check(status());

    // Async reset while in REL_CORE
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    push("t6_core_latency", 8);
    wait_sig(1, 1'b1, 50, n, saw);
    pop_check(n);
    #3;
    rst_n = 1'b0;
    #1;
    push("t6_async_reset", st(1, 0, 0, 0, 0, 0, 0));
    pop_check(status());

    // Timeout, retry and fault
    extlock = 1'b0;
    tick(2);
    rst_n = 1'b1;
    push("t3_pll_reset_len", 4);
    wait_sig(0, 1'b0, 50, n, saw);
    pop_check(n);
    push("t3_timeout1", 100);
    wait_sig(0, 1'b1, 200, n, saw);
    pop_check(n);
    push("t3_retry1", 1);
    pop_check(int'(retry_cnt));
    push("t3_pll_reset_len2", 4);
    wait_sig(0, 1'b0, 50, n, saw);
    pop_check(n);
    push("t3_timeout2", 100);
    wait_sig(3, 1'b1, 200, n, saw);
    pop_check(n);
    push("t3_fault_state", st(1, 0, 0, 0, 1, 2, 0));
    pop_check(status());
    extlock = 1'b1;
    tick(20);
    push("t3_fault_sticky", st(1, 0, 0, 0, 1, 2, 0));
    pop_check(status());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
